// File: rtl/regfile_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_port_ctrl_if
//   Bundles every non-clock signal of the register file port controller:
//   the decode issue handshake, the register file read/write ports, the
//   operand handshake to execute, the writeback input and status outputs.
//
//   modport slave  : the controller (regfile_port_ctrl)
//   modport master : the surrounding pipeline / register file
//
//   issue_*        decode -> controller instruction handshake
//   rf_src_addr_*  controller -> register file read addresses
//   rf_data_*      register file -> controller read data
//   op_*           controller -> execute operand handshake
//   wb_*           writeback stage -> controller
//   rf_write_*     controller -> register file write port
//   rf_dest_addr   controller -> register file write address
//   busy           per-register pending-write scoreboard
//   wb_error       sticky illegal-writeback flag
// ---------------------------------------------------------------------------
interface regfile_port_ctrl_if #(
   parameter int BIT_NUMBER      = 64,
   parameter int ADDR_NUMBER     = 5,
   parameter int REGISTER_NUMBER = 16
);
   logic                       issue_valid;
   logic                       issue_ready;
   logic [ADDR_NUMBER-1:0]     issue_src1;
   logic [ADDR_NUMBER-1:0]     issue_src2;
   logic [ADDR_NUMBER-1:0]     issue_dest;
   logic                       issue_has_dest;

   logic [ADDR_NUMBER-1:0]     rf_src_addr_1;
   logic [ADDR_NUMBER-1:0]     rf_src_addr_2;
   logic [BIT_NUMBER-1:0]      rf_data_1;
   logic [BIT_NUMBER-1:0]      rf_data_2;

   logic                       op_valid;
   logic                       op_ready;
   logic [BIT_NUMBER-1:0]      op_a;
   logic [BIT_NUMBER-1:0]      op_b;
   logic [ADDR_NUMBER-1:0]     op_dest;
   logic                       op_has_dest;

   logic                       wb_valid;
   logic [ADDR_NUMBER-1:0]     wb_dest;
   logic [BIT_NUMBER-1:0]      wb_data;

   logic                       rf_write_enable;
   logic [ADDR_NUMBER-1:0]     rf_dest_addr;
   logic [BIT_NUMBER-1:0]      rf_write_data;

   logic [REGISTER_NUMBER-1:0] busy;
   logic                       wb_error;

   modport slave (
      input  issue_valid, issue_src1, issue_src2, issue_dest, issue_has_dest,
      output issue_ready,
      output rf_src_addr_1, rf_src_addr_2,
      input  rf_data_1, rf_data_2,
      output op_valid, op_a, op_b, op_dest, op_has_dest,
      input  op_ready,
      input  wb_valid, wb_dest, wb_data,
      output rf_write_enable, rf_dest_addr, rf_write_data,
      output busy, wb_error
   );

   modport master (
      output issue_valid, issue_src1, issue_src2, issue_dest, issue_has_dest,
      input  issue_ready,
      input  rf_src_addr_1, rf_src_addr_2,
      output rf_data_1, rf_data_2,
      input  op_valid, op_a, op_b, op_dest, op_has_dest,
      output op_ready,
      output wb_valid, wb_dest, wb_data,
      input  rf_write_enable, rf_dest_addr, rf_write_data,
      input  busy, wb_error
   );
endinterface

// File: rtl/regfile_port_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_port_ctrl
//   Initiator side of the register file. Accepts decoded instructions, reads
//   their source operands from the register file and hands them to execute.
//   Forwards writeback results to the register file write port. A busy bit per
//   register blocks RAW and WAW hazards until the pending writeback retires.
//
//   clk    : clock, all state changes on posedge
//   reset  : synchronous, active-high; drops any in-flight op and pending
//            writebacks, clears busy and wb_error
//   bus    : regfile_port_ctrl_if.slave (issue, rf read, operand, writeback,
//            rf write, busy, wb_error)
// ---------------------------------------------------------------------------
module regfile_port_ctrl #(
   parameter int BIT_NUMBER      = 64,
   parameter int ADDR_NUMBER     = 5,
   parameter int REGISTER_NUMBER = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_port_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [ADDR_NUMBER:0] REG_LIMIT = (ADDR_NUMBER+1)'(REGISTER_NUMBER);

   function automatic logic in_range(input logic [ADDR_NUMBER-1:0] addr);
      return {1'b0, addr} < REG_LIMIT;
   endfunction

   // Out-of-range addresses match no bit, so they never look busy.
   function automatic logic busy_bit(input logic [REGISTER_NUMBER-1:0] vec,
                                     input logic [ADDR_NUMBER-1:0]     addr);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < REGISTER_NUMBER; i++) begin
         if (addr == ADDR_NUMBER'(i)) hit = vec[i];
      end
      return hit;
   endfunction

   state_t                     state;
   state_t                     state_next;
   logic [REGISTER_NUMBER-1:0] busy_q;
   logic [REGISTER_NUMBER-1:0] busy_next;
   logic                       wb_error_q;
   logic [ADDR_NUMBER-1:0]     src1_q;
   logic [ADDR_NUMBER-1:0]     src2_q;
   logic [ADDR_NUMBER-1:0]     dest_q;
   logic                       has_dest_q;
   logic                       we_q;
   logic [ADDR_NUMBER-1:0]     waddr_q;
   logic [BIT_NUMBER-1:0]      wdata_q;

   logic                       eff_has_dest;
   logic                       hazard;
   logic                       issue_ready;
   logic                       issue_fire;
   logic                       op_valid;
   logic                       wb_bad;

   assign eff_has_dest = bus.issue_has_dest & in_range(bus.issue_dest);
   assign hazard       = busy_bit(busy_q, bus.issue_src1)
                       | busy_bit(busy_q, bus.issue_src2)
                       | (eff_has_dest & busy_bit(busy_q, bus.issue_dest));
   assign issue_fire   = issue_ready & bus.issue_valid;
   assign wb_bad       = bus.wb_valid
                       & (~in_range(bus.wb_dest) | ~busy_bit(busy_q, bus.wb_dest));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      issue_ready = 1'b0;
      op_valid    = 1'b0;
      case (state)
         IDLE: begin
            issue_ready = ~hazard;
            if (bus.issue_valid && !hazard) state_next = READ;
         end
         // The register file samples the latched addresses at the edge
         // closing this state; its data is valid from then on.
         READ: state_next = HOLD;
         HOLD: begin
            op_valid = 1'b1;
            if (bus.op_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A writeback and an issue never target the same bit in one cycle: the
   // WAW check keeps the issue out while that register is still busy.
   always_comb begin
      busy_next = busy_q;
      for (int i = 0; i < REGISTER_NUMBER; i++) begin
         if (bus.wb_valid && bus.wb_dest == ADDR_NUMBER'(i)) busy_next[i] = 1'b0;
         if (issue_fire && eff_has_dest && bus.issue_dest == ADDR_NUMBER'(i))
            busy_next[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= '0;
         wb_error_q <= 1'b0;
         src1_q     <= '0;
         src2_q     <= '0;
         dest_q     <= '0;
         has_dest_q <= 1'b0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         busy_q <= busy_next;
         if (wb_bad) wb_error_q <= 1'b1;
         if (issue_fire) begin
            src1_q     <= bus.issue_src1;
            src2_q     <= bus.issue_src2;
            dest_q     <= bus.issue_dest;
            has_dest_q <= eff_has_dest;
         end
         // The register file commits on the following negedge, so a read
         // issued right after this writeback already sees the new value.
         we_q <= bus.wb_valid & in_range(bus.wb_dest);
         if (bus.wb_valid) begin
            waddr_q <= bus.wb_dest;
            wdata_q <= bus.wb_data;
         end
      end
   end

   assign bus.issue_ready     = issue_ready;
   assign bus.rf_src_addr_1   = src1_q;
   assign bus.rf_src_addr_2   = src2_q;
   assign bus.op_valid        = op_valid;
   // Sources are not busy and addresses are held, so rf_data stays stable in HOLD.
   assign bus.op_a            = (op_valid && in_range(src1_q)) ? bus.rf_data_1 : '0;
   assign bus.op_b            = (op_valid && in_range(src2_q)) ? bus.rf_data_2 : '0;
   assign bus.op_dest         = dest_q;
   assign bus.op_has_dest     = has_dest_q;
   assign bus.rf_write_enable = we_q;
   assign bus.rf_dest_addr    = waddr_q;
   assign bus.rf_write_data   = wdata_q;
   assign bus.busy            = busy_q;
   assign bus.wb_error        = wb_error_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_ctrl
//   Scoreboard bench for regfile_port_ctrl. The stimulus process keeps a
//   behavioural model (register contents, pending-write set, error flag) and
//   queues the operands each accepted instruction must deliver; a separate
//   monitor compares every DUT output on the negedge. Also contains a simple
//   register file model (posedge-registered reads, negedge writes).
// ---------------------------------------------------------------------------
module tb_regfile_port_ctrl;
   localparam int BN = 64;
   localparam int AN = 5;
   localparam int RN = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regfile_port_ctrl_if #(.BIT_NUMBER(BN), .ADDR_NUMBER(AN), .REGISTER_NUMBER(RN)) bus();

   regfile_port_ctrl #(.BIT_NUMBER(BN), .ADDR_NUMBER(AN), .REGISTER_NUMBER(RN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // register file model
   logic [BN-1:0] rf_mem [32];
   always @(posedge clk) begin
      bus.rf_data_1 <= rf_mem[bus.rf_src_addr_1];
      bus.rf_data_2 <= rf_mem[bus.rf_src_addr_2];
   end
   always @(negedge clk) begin
      if (bus.rf_write_enable) rf_mem[bus.rf_dest_addr] <= bus.rf_write_data;
   end

   // reference model
   typedef struct {
      logic [BN-1:0] a;
      logic [BN-1:0] b;
      logic [AN-1:0] s1;
      logic [AN-1:0] s2;
      logic [AN-1:0] d;
      logic          hd;
      int            acc;
   } op_t;

   logic [BN-1:0] ref_regs [RN];
   logic [RN-1:0] m_busy = '0;
   logic          m_err  = 1'b0;
   logic          m_we   = 1'b0;
   logic [AN-1:0] m_wa   = '0;
   logic [BN-1:0] m_wd   = '0;
   op_t           exp_q [$];

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b0;
   bit fired  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit inr(input logic [AN-1:0] a);
      return a < 5'(RN);
   endfunction

   function automatic logic [BN-1:0] src_val(input logic [AN-1:0] a);
      return inr(a) ? ref_regs[a[3:0]] : '0;
   endfunction

   function automatic bit hz_f(input logic [AN-1:0] s1, input logic [AN-1:0] s2,
                               input logic [AN-1:0] d, input logic hd);
      return (inr(s1) && m_busy[s1[3:0]]) || (inr(s2) && m_busy[s2[3:0]])
          || (hd && inr(d) && m_busy[d[3:0]]);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // one clock of stimulus; model advances at the posedge the DUT samples
   task automatic step();
      bit  fire;
      int  acc;
      op_t e;
      @(negedge clk);
      fire = bus.issue_valid && bus.issue_ready;
      acc  = cyc;
      @(posedge clk);
      if (reset) begin
         m_busy = '0;
         m_err  = 1'b0;
         m_we   = 1'b0;
         m_wa   = '0;
         m_wd   = '0;
         exp_q.delete();
         fire   = 1'b0;
      end else begin
         if (bus.wb_valid) begin
            m_wa = bus.wb_dest;
            m_wd = bus.wb_data;
            if (inr(bus.wb_dest)) begin
               if (!m_busy[bus.wb_dest[3:0]]) m_err = 1'b1;
               m_busy[bus.wb_dest[3:0]]   = 1'b0;
               ref_regs[bus.wb_dest[3:0]] = bus.wb_data;
            end else begin
               m_err = 1'b1;
            end
         end
         m_we = bus.wb_valid && inr(bus.wb_dest);
         if (fire) begin
            e.a   = src_val(bus.issue_src1);
            e.b   = src_val(bus.issue_src2);
            e.s1  = bus.issue_src1;
            e.s2  = bus.issue_src2;
            e.d   = bus.issue_dest;
            e.hd  = bus.issue_has_dest && inr(bus.issue_dest);
            e.acc = acc;
            exp_q.push_back(e);
            if (e.hd) m_busy[bus.issue_dest[3:0]] = 1'b1;
         end
      end
      fired = fire;
      #1;
      if (fire) bus.issue_valid = 1'b0;
      bus.wb_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic wb(input logic [AN-1:0] d, input logic [BN-1:0] v);
      bus.wb_valid = 1'b1;
      bus.wb_dest  = d;
      bus.wb_data  = v;
      step();
   endtask

   task automatic issue_set(input logic [AN-1:0] s1, input logic [AN-1:0] s2,
                            input logic [AN-1:0] d, input logic hd);
      bus.issue_valid    = 1'b1;
      bus.issue_src1     = s1;
      bus.issue_src2     = s2;
      bus.issue_dest     = d;
      bus.issue_has_dest = hd;
   endtask

   task automatic wait_fire(input string name, input int max);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!fired && k < max);
      if (!fired) chk({name, "_issue_timeout"}, 64'(0), 64'(1));
   endtask

   task automatic wait_drain(input string name, input int max);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || bus.issue_valid) && k < max) begin
         step();
         k++;
      end
      chk({name, "_drain"}, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic wb_any_busy();
      int  start;
      int  idx;
      bit  found;
      start = $urandom_range(0, RN - 1);
      found = 1'b0;
      idx   = 0;
      for (int j = 0; j < RN; j++) begin
         if (!found && m_busy[(start + j) % RN]) begin
            idx   = (start + j) % RN;
            found = 1'b1;
         end
      end
      if (found) begin
         bus.wb_valid = 1'b1;
         bus.wb_dest  = 5'(idx);
         bus.wb_data  = {$urandom, $urandom};
      end
   endtask

   // monitor / scoreboard checker
   initial begin
      bit exp_ov;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("issue_ready", 64'(bus.issue_ready),
                64'(exp_q.size() == 0 &&
                    !hz_f(bus.issue_src1, bus.issue_src2, bus.issue_dest, bus.issue_has_dest)));
            chk("busy", 64'(bus.busy), 64'(m_busy));
            chk("wb_error", 64'(bus.wb_error), 64'(m_err));
            chk("rf_write_enable", 64'(bus.rf_write_enable), 64'(m_we));
            chk("rf_dest_addr", 64'(bus.rf_dest_addr), 64'(m_wa));
            chk("rf_write_data", bus.rf_write_data, m_wd);
            exp_ov = (exp_q.size() != 0) && (cyc >= exp_q[0].acc + 2);
            chk("op_valid", 64'(bus.op_valid), 64'(exp_ov));
            if (bus.op_valid && exp_q.size() != 0) begin
               chk("op_a", bus.op_a, exp_q[0].a);
               chk("op_b", bus.op_b, exp_q[0].b);
               chk("op_dest", 64'(bus.op_dest), 64'(exp_q[0].d));
               chk("op_has_dest", 64'(bus.op_has_dest), 64'(exp_q[0].hd));
               chk("rf_src_addr_1", 64'(bus.rf_src_addr_1), 64'(exp_q[0].s1));
               chk("rf_src_addr_2", 64'(bus.rf_src_addr_2), 64'(exp_q[0].s2));
               if (bus.op_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [AN-1:0] s1, s2, d;
      logic          hd;

      bus.issue_valid    = 1'b0;
      bus.issue_src1     = '0;
      bus.issue_src2     = '0;
      bus.issue_dest     = '0;
      bus.issue_has_dest = 1'b0;
      bus.op_ready       = 1'b1;
      bus.wb_valid       = 1'b0;
      bus.wb_dest        = '0;
      bus.wb_data        = '0;
      for (int i = 0; i < RN; i++) ref_regs[i] = '0;

      do_reset();
      mon_en = 1'b1;

      // give every implemented register a known value
      for (int r = 0; r < RN; r++) wb(5'(r), {$urandom, $urandom});
      step();
      do_reset();

      // 1: write r3, read it on both ports
      wb(5'd3, 64'hA5);
      issue_set(5'd3, 5'd3, 5'd0, 1'b0);
      wait_fire("t1", 4);
      wait_drain("t1", 10);

      // 2: RAW stall on r5 until its writeback
      do_reset();
      issue_set(5'd0, 5'd1, 5'd5, 1'b1);
      wait_fire("t2a", 4);
      issue_set(5'd5, 5'd0, 5'd9, 1'b0);
      repeat (5) step();
      wb(5'd5, 64'h1234);
      wait_fire("t2b", 4);
      wait_drain("t2", 10);

      // 3: execute back-pressure holds operands while a new issue waits
      bus.op_ready = 1'b0;
      issue_set(5'd1, 5'd2, 5'd0, 1'b0);
      wait_fire("t3a", 4);
      issue_set(5'd3, 5'd4, 5'd6, 1'b1);
      repeat (6) step();
      bus.op_ready = 1'b1;
      wait_drain("t3", 12);
      wb(5'd6, {$urandom, $urandom});

      // 4: writeback to a register nobody is waiting on
      do_reset();
      wb(5'd7, 64'hDEAD_BEEF_0000_0007);
      repeat (2) step();
      issue_set(5'd7, 5'd7, 5'd0, 1'b0);
      wait_fire("t4", 4);
      wait_drain("t4", 10);

      // 5: out-of-range sources and destination
      issue_set(5'd20, 5'd1, 5'd31, 1'b1);
      wait_fire("t5a", 4);
      issue_set(5'd2, 5'd25, 5'd16, 1'b1);
      wait_fire("t5b", 4);
      wait_drain("t5", 10);

      // 6: reset while the read is in progress
      issue_set(5'd0, 5'd1, 5'd2, 1'b1);
      wait_fire("t6", 4);
      do_reset();
      repeat (2) step();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         if (!bus.issue_valid && $urandom_range(0, 99) < 60) begin
            s1 = ($urandom_range(0, 99) < 10) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            s2 = ($urandom_range(0, 99) < 10) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            d  = 5'($urandom_range(0, 17));
            hd = 1'($urandom_range(0, 1));
            if (d == s1 || d == s2) hd = 1'b0;
            issue_set(s1, s2, d, hd);
         end
         bus.op_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) < 30) wb_any_busy();
         else if ($urandom_range(0, 59) == 0) begin
            bus.wb_valid = 1'b1;
            bus.wb_dest  = 5'($urandom_range(16, 31));
            bus.wb_data  = {$urandom, $urandom};
         end
         step();
      end

      // drain everything still pending
      bus.op_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() != 0 || bus.issue_valid || m_busy != '0) begin
            wb_any_busy();
            step();
         end
      end
      chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
      chk("final_busy_clear", 64'(bus.busy), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
